// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared types and constants for the
// USB receive-path stages.
package usb_rx_pkg;

  localparam int USB_STUFF_LEN = 6;
  localparam int USB_BYTE_W    = 8;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    ERR
  } rx_unstuff_state_t;

endpackage

// File: rtl/stuff_detector.sv
// stuff_detector: tracks the run of consecutive ones
// and classifies the current bit as stuffed or illegal.
module stuff_detector
  import usb_rx_pkg::*;
#(
  parameter int STUFF_LEN = USB_STUFF_LEN
) (
  input  logic clk,
  input  logic RST,
  input  logic clear,
  input  logic bit_en,
  input  logic bit_in,
  output logic is_stuff,
  output logic is_violation
);

  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam logic [OW-1:0] RUN_MAX = OW'(STUFF_LEN);

  logic [OW-1:0] ones_cnt;
  logic          at_max;

  assign at_max       = (ones_cnt == RUN_MAX);
  assign is_stuff     = at_max & ~bit_in;
  assign is_violation = at_max & bit_in;

  // Run length of ones; a zero or a full run restarts it.
  always_ff @(posedge clk) begin
    if (RST) begin
      ones_cnt <= '0;
    end else if (clear) begin
      ones_cnt <= '0;
    end else if (bit_en) begin
      if (at_max || !bit_in) begin
        ones_cnt <= '0;
      end else begin
        ones_cnt <= ones_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rx_bit_unstuffer.sv
// rx_bit_unstuffer: removes stuffed zeros and packs bits
// LSB-first into bytes. Option: RX_UNSTUFF_BIT_OUT_EN.
module rx_bit_unstuffer
  import usb_rx_pkg::*;
#(
  parameter int STUFF_LEN = USB_STUFF_LEN,
  parameter int DATA_W    = USB_BYTE_W
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              rx_active,
  input  logic              bit_valid,
  input  logic              decoded_bit,
  output logic [DATA_W-1:0] rx_byte,
  output logic              byte_valid,
  output logic              stuff_err,
  output logic              align_err
`ifdef RX_UNSTUFF_BIT_OUT_EN
  ,
  output logic              unstuffed_bit,
  output logic              unstuffed_valid
`endif
);

  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);

  rx_unstuff_state_t state_q;
  rx_unstuff_state_t state_d;

  logic [BW-1:0]     bit_cnt_q;
  logic [BW-1:0]     bit_cnt_d;
  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] shreg_d;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] byte_d;
  logic              byte_valid_d;
  logic              stuff_err_d;
  logic              align_err_d;
  logic              det_clear;
  logic              det_en;
  logic              is_stuff;
  logic              is_violation;

  assign shifted = {decoded_bit, shreg_q[DATA_W-1:1]};

  stuff_detector #(
    .STUFF_LEN(STUFF_LEN)
  ) u_det (
    .clk         (clk),
    .RST         (RST),
    .clear       (det_clear),
    .bit_en      (det_en),
    .bit_in      (decoded_bit),
    .is_stuff    (is_stuff),
    .is_violation(is_violation)
  );

  // Next state, datapath updates and next output values.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    byte_d       = rx_byte;
    byte_valid_d = 1'b0;
    stuff_err_d  = 1'b0;
    align_err_d  = 1'b0;
    det_clear    = 1'b0;
    det_en       = 1'b0;
    unique case (state_q)
      IDLE: begin
        det_clear = 1'b1;
        bit_cnt_d = '0;
        shreg_d   = '0;
        if (rx_active) begin
          state_d = RECV;
        end
      end
      RECV: begin
        if (!rx_active) begin
          state_d     = IDLE;
          align_err_d = (bit_cnt_q != '0);
          det_clear   = 1'b1;
          bit_cnt_d   = '0;
          shreg_d     = '0;
        end else if (bit_valid) begin
          det_en = 1'b1;
          if (is_violation) begin
            state_d     = ERR;
            stuff_err_d = 1'b1;
            det_clear   = 1'b1;
            bit_cnt_d   = '0;
            shreg_d     = '0;
          end else if (!is_stuff) begin
            shreg_d = shifted;
            if (bit_cnt_q == LAST) begin
              bit_cnt_d    = '0;
              byte_d       = shifted;
              byte_valid_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
      end
      ERR: begin
        det_clear = 1'b1;
        bit_cnt_d = '0;
        shreg_d   = '0;
        if (!rx_active) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        det_clear = 1'b1;
        bit_cnt_d = '0;
        shreg_d   = '0;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      stuff_err  <= 1'b0;
      align_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      rx_byte    <= byte_d;
      byte_valid <= byte_valid_d;
      stuff_err  <= stuff_err_d;
      align_err  <= align_err_d;
    end
  end

`ifdef RX_UNSTUFF_BIT_OUT_EN
  logic take;

  assign take = (state_q == RECV) & rx_active & bit_valid
              & ~is_stuff & ~is_violation;

  // Echo every accepted data bit one cycle later.
  always_ff @(posedge clk) begin
    if (RST) begin
      unstuffed_bit   <= 1'b0;
      unstuffed_valid <= 1'b0;
    end else begin
      unstuffed_valid <= take;
      if (take) begin
        unstuffed_bit <= decoded_bit;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rx_bit_unstuffer.sv
// tb_rx_bit_unstuffer: directed and random stimulus
// against a queue-based model of the unstuffer.
module tb_rx_bit_unstuffer;

  localparam int SL = 6;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          RST;
  logic          rx_active;
  logic          bit_valid;
  logic          decoded_bit;
  logic [DW-1:0] rx_byte;
  logic          byte_valid;
  logic          stuff_err;
  logic          align_err;
`ifdef RX_UNSTUFF_BIT_OUT_EN
  logic          unstuffed_bit;
  logic          unstuffed_valid;
`endif

  int checks = 0;
  int errors = 0;

  int            m_mode;
  int            m_run;
  logic          m_bits[$];
  logic [DW-1:0] m_byte;
  logic          m_bv;
  logic          m_se;
  logic          m_ae;
  logic          m_ub;
  logic          m_uv;

  always #5 clk = ~clk;

  rx_bit_unstuffer dut (
    .clk            (clk),
    .RST            (RST),
    .rx_active      (rx_active),
    .bit_valid      (bit_valid),
    .decoded_bit    (decoded_bit),
    .rx_byte        (rx_byte),
    .byte_valid     (byte_valid),
    .stuff_err      (stuff_err),
    .align_err      (align_err)
`ifdef RX_UNSTUFF_BIT_OUT_EN
    ,
    .unstuffed_bit  (unstuffed_bit),
    .unstuffed_valid(unstuffed_valid)
`endif
  );

  function automatic logic [15:0] obs();
    logic [15:0] v;
    v         = '0;
    v[DW-1:0] = rx_byte;
    v[8]      = byte_valid;
    v[9]      = stuff_err;
    v[10]     = align_err;
`ifdef RX_UNSTUFF_BIT_OUT_EN
    v[11]     = unstuffed_bit;
    v[12]     = unstuffed_valid;
`endif
    return v;
  endfunction

  function automatic logic [15:0] expv();
    logic [15:0] v;
    v         = '0;
    v[DW-1:0] = m_byte;
    v[8]      = m_bv;
    v[9]      = m_se;
    v[10]     = m_ae;
`ifdef RX_UNSTUFF_BIT_OUT_EN
    v[11]     = m_ub;
    v[12]     = m_uv;
`endif
    return v;
  endfunction

  // Mode 0 idle, 1 receiving, 2 error; bits of the current
  // byte are kept as a queue and packed when eight arrive.
  function automatic void model_edge(logic r, logic a,
                                     logic v, logic b);
    logic [DW-1:0] acc;
    m_bv = 1'b0;
    m_se = 1'b0;
    m_ae = 1'b0;
    m_uv = 1'b0;
    if (r) begin
      m_mode = 0;
      m_run  = 0;
      m_bits.delete();
      m_byte = '0;
      m_ub   = 1'b0;
    end else if (m_mode == 0) begin
      m_run = 0;
      m_bits.delete();
      if (a) m_mode = 1;
    end else if (m_mode == 1) begin
      if (!a) begin
        m_mode = 0;
        m_ae   = (m_bits.size() != 0);
        m_run  = 0;
        m_bits.delete();
      end else if (v) begin
        if (m_run == SL && !b) begin
          m_run = 0;
        end else if (m_run == SL) begin
          m_se   = 1'b1;
          m_mode = 2;
          m_run  = 0;
          m_bits.delete();
        end else begin
          m_bits.push_back(b);
          m_run = b ? m_run + 1 : 0;
          m_uv  = 1'b1;
          m_ub  = b;
          if (m_bits.size() == DW) begin
            acc = '0;
            foreach (m_bits[i]) acc[i] = m_bits[i];
            m_byte = acc;
            m_bv   = 1'b1;
            m_bits.delete();
          end
        end
      end
    end else begin
      m_run = 0;
      m_bits.delete();
      if (!a) m_mode = 0;
    end
  endfunction

  task automatic tick(input logic r, input logic a,
                      input logic v, input logic b);
    RST         = r;
    rx_active   = a;
    bit_valid   = v;
    decoded_bit = b;
    @(posedge clk);
    model_edge(r, a, v, b);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (rx_byte !== 8'h00) begin
      errors++;
      $display("FAIL reset_byte got %h want 00", rx_byte);
    end
    checks++;
    if ({byte_valid, stuff_err, align_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_pulses got %b want 000",
               {byte_valid, stuff_err, align_err});
    end
    checks++;
    if (obs() !== expv()) begin
      errors++;
      $display("FAIL reset_model got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_clean_byte();
    logic [7:0] pat = 8'h4D;
    int nbv = 0;
    int nerr = 0;
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1, 1'b1, pat[i]);
      nbv += int'(byte_valid);
      nerr += int'(stuff_err) + int'(align_err);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL clean_cyc%0d got %h want %h", i, obs(), expv());
      end
    end
    checks++;
    if (byte_valid !== 1'b1 || rx_byte !== 8'h4D) begin
      errors++;
      $display("FAIL clean_byte got %b/%h want 1/4d",
               byte_valid, rx_byte);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    nbv += int'(byte_valid);
    nerr += int'(stuff_err) + int'(align_err);
    checks++;
    if (nbv != 1 || nerr != 0) begin
      errors++;
      $display("FAIL clean_pulses got bv=%0d err=%0d want 1/0",
               nbv, nerr);
    end
  endtask

  task automatic test_stuffed_byte();
    logic [8:0] pat = 9'b110111111;
    int nbv = 0;
    int nerr = 0;
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      tick(1'b0, 1'b1, 1'b1, pat[i]);
      nbv += int'(byte_valid);
      nerr += int'(stuff_err) + int'(align_err);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL stuffed_cyc%0d got %h want %h", i, obs(), expv());
      end
    end
    checks++;
    if (byte_valid !== 1'b1 || rx_byte !== 8'hFF) begin
      errors++;
      $display("FAIL stuffed_byte got %b/%h want 1/ff",
               byte_valid, rx_byte);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    nerr += int'(align_err);
    checks++;
    if (nbv != 1 || nerr != 0) begin
      errors++;
      $display("FAIL stuffed_pulses got bv=%0d err=%0d want 1/0",
               nbv, nerr);
    end
  endtask

  task automatic test_cross_boundary();
    logic [16:0] pat = 17'h002FC;
    logic [7:0] got[$];
    int nerr = 0;
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) begin
      tick(1'b0, 1'b1, 1'b1, pat[i]);
      if (byte_valid === 1'b1) got.push_back(rx_byte);
      nerr += int'(stuff_err) + int'(align_err);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL cross_cyc%0d got %h want %h", i, obs(), expv());
      end
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    nerr += int'(align_err);
    checks++;
    if (got.size() != 2 || nerr != 0) begin
      errors++;
      $display("FAIL cross_count got n=%0d err=%0d want 2/0",
               got.size(), nerr);
    end else begin
      checks++;
      if (got[0] !== 8'hFC || got[1] !== 8'h01) begin
        errors++;
        $display("FAIL cross_bytes got %h %h want fc 01",
                 got[0], got[1]);
      end
    end
  endtask

  task automatic test_violation();
    logic [14:0] pat = 15'b101101001111111;
    int nbv = 0;
    int nse = 0;
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      tick(1'b0, 1'b1, 1'b1, pat[i]);
      nbv += int'(byte_valid);
      nse += int'(stuff_err);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL viol_cyc%0d got %h want %h", i, obs(), expv());
      end
      if (i == 6) begin
        checks++;
        if (stuff_err !== 1'b1) begin
          errors++;
          $display("FAIL viol_pulse got %b want 1", stuff_err);
        end
      end
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (align_err !== 1'b0 || nbv != 0 || nse != 1) begin
      errors++;
      $display("FAIL viol_end got ae=%b bv=%0d se=%0d want 0/0/1",
               align_err, nbv, nse);
    end
  endtask

  task automatic test_partial();
    logic [7:0] pat = 8'h4D;
    int nae = 0;
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b1, 1'b1, pat[i]);
      nae += int'(align_err);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    nae += int'(align_err);
    checks++;
    if (align_err !== 1'b1) begin
      errors++;
      $display("FAIL partial_ae got %b want 1", align_err);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    nae += int'(align_err);
    checks++;
    if (nae != 1) begin
      errors++;
      $display("FAIL partial_once got %0d want 1", nae);
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1, 1'b1, pat[i]);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL partial_cyc%0d got %h want %h", i, obs(), expv());
      end
    end
    checks++;
    if (byte_valid !== 1'b1 || rx_byte !== 8'h4D) begin
      errors++;
      $display("FAIL partial_next got %b/%h want 1/4d",
               byte_valid, rx_byte);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [7:0] pat = 8'hA5;
    int nbv = 0;
    int nerr = 0;
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs() !== 16'h0000) begin
      errors++;
      $display("FAIL rstmid_clear got %h want 0000", obs());
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    nbv += int'(byte_valid);
    nerr += int'(stuff_err) + int'(align_err);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1, 1'b1, pat[i]);
      nbv += int'(byte_valid);
      nerr += int'(stuff_err) + int'(align_err);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL rstmid_cyc%0d got %h want %h", i, obs(), expv());
      end
    end
    checks++;
    if (rx_byte !== 8'hA5 || nbv != 1 || nerr != 0) begin
      errors++;
      $display("FAIL rstmid_byte got %h bv=%0d err=%0d want a5/1/0",
               rx_byte, nbv, nerr);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat = 8'h3C;
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (align_err !== 1'b1 || obs() !== expv()) begin
      errors++;
      $display("FAIL b2b_fall got %h want %h", obs(), expv());
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1, 1'b1, pat[i]);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL b2b_cyc%0d got %h want %h", i, obs(), expv());
      end
    end
    checks++;
    if (byte_valid !== 1'b1 || rx_byte !== 8'h3C) begin
      errors++;
      $display("FAIL b2b_byte got %b/%h want 1/3c",
               byte_valid, rx_byte);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int   run;
    int   nb;
    int   gap;
    logic clean;
    logic v;
    logic b;
    logic r;
    for (int p = 0; p < 80; p++) begin
      clean = ($urandom_range(0, 3) != 0);
      run   = 0;
      tick(1'b0, 1'b1, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL rand_p%0d_enter got %h want %h",
                 p, obs(), expv());
      end
      nb = $urandom_range(0, 40);
      for (int i = 0; i < nb; i++) begin
        v = ($urandom_range(0, 3) != 0);
        b = ($urandom_range(0, 9) < 7);
        if (clean && v && run == SL) b = 1'b0;
        if (v) run = b ? run + 1 : 0;
        r = (i == nb / 2) && ($urandom_range(0, 15) == 0);
        if (r) run = 0;
        tick(r, 1'b1, v, b);
        checks++;
        if (obs() !== expv()) begin
          errors++;
          $display("FAIL rand_p%0d_b%0d got %h want %h",
                   p, i, obs(), expv());
        end
      end
      gap = $urandom_range(1, 3);
      for (int j = 0; j < gap; j++) begin
        tick(1'b0, 1'b0, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
        checks++;
        if (obs() !== expv()) begin
          errors++;
          $display("FAIL rand_p%0d_g%0d got %h want %h",
                   p, j, obs(), expv());
        end
      end
    end
  endtask

  initial begin
    RST         = 1'b1;
    rx_active   = 1'b0;
    bit_valid   = 1'b0;
    decoded_bit = 1'b0;
    m_mode      = 0;
    m_run       = 0;
    m_byte      = '0;
    m_bv        = 1'b0;
    m_se        = 1'b0;
    m_ae        = 1'b0;
    m_ub        = 1'b0;
    m_uv        = 1'b0;
    test_reset();
    test_clean_byte();
    test_stuffed_byte();
    test_cross_boundary();
    test_violation();
    test_partial();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_bit_unstuffer.md
Name: rx_bit_unstuffer

Overview:
Receive-path stage directly downstream of the NRZI decoder. Consumes the decoded bit stream, one bit per bit strobe. Removes the stuffed zero that follows every run of STUFF_LEN consecutive ones, flags bit-stuff violations, and deserialises data bits LSB-first into bytes for the packet layer.

Parameters:
STUFF_LEN, 6, count of consecutive ones after which one stuffed zero is expected
DATA_W, 8, output word width in bits

Ports:
clk  input  1  system clock
RST  input  1  synchronous, active-high reset
rx_active  input  1  high while a packet is being received (after SYNC, before EOP)
bit_valid  input  1  one-cycle strobe; decoded_bit is valid this cycle
decoded_bit  input  1  NRZI-decoded bit from the upstream decoder
rx_byte  output  DATA_W  assembled data byte, LSB received first
byte_valid  output  1  one-cycle pulse; rx_byte is valid
stuff_err  output  1  one-cycle pulse on a bit-stuff violation
align_err  output  1  one-cycle pulse when rx_active falls with a partial byte

Behaviour:
- Reset (RST high at a clk edge): state=IDLE; ones_cnt=0, bit_cnt=0, shreg=0; rx_byte=0; byte_valid=0, stuff_err=0, align_err=0.
- All outputs are registered. The pulse outputs are high for exactly one cycle.
- A bit is accepted only when bit_valid=1 and rx_active=1 in the same cycle. Otherwise bit_valid is ignored.
- States:
  - IDLE: counters held at 0. When rx_active=1, go to RECV.
  - RECV: processes accepted bits (rules below).
    - If rx_active=0, go to IDLE. Pulse align_err next cycle if bit_cnt!=0. Clear all counters.
  - ERR: all bits ignored. When rx_active=0, go to IDLE. No align_err is raised from ERR.
- Bit rules in RECV, for each accepted bit:
  - ones_cnt==STUFF_LEN and bit=0: stuffed bit. Discard it; ones_cnt=0; bit_cnt unchanged.
  - ones_cnt==STUFF_LEN and bit=1: violation. Pulse stuff_err next cycle; go to ERR; the partial byte is dropped.
  - Otherwise it is a data bit:
    - shreg = {bit, shreg[DATA_W-1:1]}.
    - ones_cnt = bit ? ones_cnt+1 : 0.
    - bit_cnt = bit_cnt+1, wrapping at DATA_W.
- Byte completion: when the data bit taken with bit_cnt==DATA_W-1 is accepted:
  - next cycle, rx_byte = {bit, shreg[DATA_W-1:1]} and byte_valid=1;
  - bit_cnt wraps to 0.
  - Latency is 1 cycle from the 8th data-bit strobe.
- rx_byte holds its value until the next completed byte.
- ones_cnt carries across byte boundaries. A stuffed zero can fall between bytes or at the start of the next byte.
- ones_cnt width is clog2(STUFF_LEN+1). bit_cnt width is clog2(DATA_W).
- Simultaneous rx_active fall and bit_valid: the bit is not accepted. Only the end-of-packet handling runs.
- rx_active re-asserted one cycle after falling: IDLE→RECV with counters already cleared.
- RST mid-packet: immediate return to reset values. Pulses pending for the next cycle are suppressed.

Optional Feature:
Macro: RX_UNSTUFF_BIT_OUT_EN
- Defined: adds ports unstuffed_bit (out, 1) and unstuffed_valid (out, 1).
  - Both are registered.
  - unstuffed_valid pulses one cycle after each accepted data bit; unstuffed_bit carries that bit.
  - Stuffed bits and violating bits produce no pulse.
- Undefined: ports and logic are absent. All other behaviour is identical.

Decomposition:
- Package usb_rx_pkg:
  - state enum rx_unstuff_state_t {IDLE, RECV, ERR};
  - constants USB_STUFF_LEN=6 and USB_BYTE_W=8, used as parameter defaults.
- One sub-module, stuff_detector:
  - contains the ones_cnt register;
  - inputs: clk, RST, clear, bit_en, bit;
  - outputs: is_stuff, is_violation, combinational from the current ones_cnt and bit.
- Top level holds the FSM, the shift register, bit_cnt and the output registers.

Test Plan:
- Clean byte: rx_active=1, bits 1,0,1,1,0,0,1,0 → byte_valid one cycle after the 8th strobe, rx_byte=8'h4D; no errors.
- Stuffed byte: bits 1,1,1,1,1,1,0(stuffed),1,1 → rx_byte=8'hFF, byte_valid once; the 0 is discarded.
- Cross-boundary stuff: byte 8'hFC (data 0,0,1,1,1,1,1,1), stuffed 0, then 8'h01 (data 1,0,0,0,0,0,0,0) → byte_valid pulses with 8'hFC then 8'h01; no stuff_err.
- Violation: seven consecutive 1s → stuff_err pulses one cycle after the 7th strobe; no byte_valid; further bits ignored; rx_active low → IDLE, no align_err.
- Partial byte: 5 data bits then rx_active=0 → align_err pulses once; the next packet's first byte decodes correctly from bit_cnt=0.
- Reset mid-byte: 4 bits, RST=1 for 1 cycle, then 8 bits of 8'hA5 → rx_byte=8'hA5; no spurious pulses after reset.
